// File: rtl/mcu_spi_port_mux.sv
// Routes one of NUM_PORTS MCU SPI links to the core. A port is taken over only
// after its debounced chip-select request is seen while the current link is idle.
module mcu_spi_port_mux #(
  parameter int NUM_PORTS      = 2,
  parameter int DEFAULT_PORT   = 0,
  parameter int SYNC_STAGES    = 2,
  parameter int DETECT_CYCLES  = 16,
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter bit FANOUT_ALL     = 1'b1,
  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk32,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] port_sclk,
  input  logic [NUM_PORTS-1:0] port_csn,
  input  logic [NUM_PORTS-1:0] port_mosi,
  output logic [NUM_PORTS-1:0] port_miso,
  output logic [NUM_PORTS-1:0] port_intn,
  output logic                 mcu_sclk,
  output logic                 mcu_csn,
  output logic                 mcu_mosi,
  input  logic                 mcu_miso,
  input  logic                 mcu_intn,
  output logic [SEL_W-1:0]     port_sel,
  output logic                 switching
);

  localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [SEL_W-1:0] DEF_SEL    = SEL_W'(DEFAULT_PORT);
  localparam logic [7:0]       DET_MAX    = 8'(DETECT_CYCLES);
  localparam logic [7:0]       GUARD_LAST = 8'(GUARD_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic {RUN, GUARD} state_e;

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       portSel_q, portSel_d;
  logic [SEL_W-1:0]       target_q, target_d;
  logic [7:0]             guardCnt_q, guardCnt_d;
  logic [TO_W-1:0]        idleCnt_q, idleCnt_d;
  logic [SYNC_STAGES-1:0] sync_q [NUM_PORTS];
  logic [7:0]             detCnt_q [NUM_PORTS];

  logic [NUM_PORTS-1:0] csnSync;
  logic [NUM_PORTS-1:0] req;
  logic [SEL_W-1:0]     reqTarget;
  logic                 reqFound;
  logic                 idle;
  logic                 timeoutHit;

  // Synchronisers preset high so an unconnected port looks idle out of reset.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        sync_q[i]   <= '1;
        detCnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], port_csn[i]};
        if (csnSync[i]) begin
          detCnt_q[i] <= '0;
        end else if (detCnt_q[i] != DET_MAX) begin
          detCnt_q[i] <= detCnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    csnSync   = '0;
    req       = '0;
    reqFound  = 1'b0;
    reqTarget = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      csnSync[i] = sync_q[i][SYNC_STAGES-1];
      req[i]     = (detCnt_q[i] == DET_MAX);
    end
    // Descending scan so the lowest requesting index is the one left standing.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i] && (SEL_W'(i) != portSel_q)) begin
        reqFound  = 1'b1;
        reqTarget = SEL_W'(i);
      end
    end
    idle       = csnSync[portSel_q];
    timeoutHit = (TIMEOUT_CYCLES > 0) && (portSel_q != DEF_SEL) && (idleCnt_q == TO_MAX);
  end

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      portSel_q  <= DEF_SEL;
      target_q   <= DEF_SEL;
      guardCnt_q <= '0;
      idleCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      portSel_q  <= portSel_d;
      target_q   <= target_d;
      guardCnt_q <= guardCnt_d;
      idleCnt_q  <= idleCnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    portSel_d  = portSel_q;
    target_d   = target_q;
    guardCnt_d = guardCnt_q;
    case (state_q)
      RUN: begin
        if (idle && (reqFound || timeoutHit)) begin
          state_d    = GUARD;
          target_d   = reqFound ? reqTarget : DEF_SEL;
          guardCnt_d = '0;
        end
      end
      GUARD: begin
        if (guardCnt_q == GUARD_LAST) begin
          state_d   = RUN;
          portSel_d = target_q;
        end else begin
          guardCnt_d = guardCnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
    // Idle time is measured per selection, so a new port starts from zero.
    idleCnt_d = idleCnt_q;
    if (!idle || (portSel_d != portSel_q)) begin
      idleCnt_d = '0;
    end else if (idleCnt_q != TO_MAX) begin
      idleCnt_d = idleCnt_q + TO_W'(1);
    end
  end

  always_comb begin
    switching = (state_q == GUARD);
    port_sel  = portSel_q;
    mcu_csn   = 1'b1;
    mcu_sclk  = 1'b0;
    mcu_mosi  = 1'b0;
    port_miso = '1;
    port_intn = '1;
    if (state_q == RUN) begin
      mcu_csn  = port_csn[portSel_q];
      mcu_sclk = port_sclk[portSel_q];
      mcu_mosi = port_mosi[portSel_q];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (FANOUT_ALL || ((state_q == RUN) && (SEL_W'(i) == portSel_q))) begin
        port_miso[i] = mcu_miso;
        port_intn[i] = mcu_intn;
      end
    end
  end

endmodule

// File: doc/mcu_spi_port_mux.md
Name: mcu_spi_port_mux

Overview:
- N-input selector for the MCU SPI control link (sclk/csn/mosi in, miso/intn out). It generalises the fixed two-way on-board/external MCU switch.
- Sits between the board MCU pins and the core's mcu_* interface.
- Detects which MCU port is alive by debounced chip-select activity. It switches ports only while the link is idle, with a guard gap.
- Optionally falls back to the default port after an idle timeout.

Parameters:
- NUM_PORTS, 2, number of MCU SPI ports (2..8).
- DEFAULT_PORT, 0, port selected after reset and on timeout fallback.
- SYNC_STAGES, 2, synchronizer depth on each csn input used for detection (>=2).
- DETECT_CYCLES, 16, consecutive synced-low csn cycles needed to register a port request (1..255).
- GUARD_CYCLES, 4, cycles the output csn is forced high during a switch (1..255).
- TIMEOUT_CYCLES, 0, idle cycles before a non-default selection reverts to DEFAULT_PORT. 0 means sticky (never revert).
- FANOUT_ALL, 1, 1: miso/intn driven to every port. 0: non-selected ports get miso=1, intn=1.

Ports:
- clk32  in  1  system clock (32 MHz)
- reset_n  in  1  asynchronous active-low reset
- port_sclk  in  NUM_PORTS  SPI clock from each MCU port
- port_csn  in  NUM_PORTS  SPI chip select (active low) from each port
- port_mosi  in  NUM_PORTS  MCU-to-FPGA data from each port
- port_miso  out  NUM_PORTS  FPGA-to-MCU data to each port
- port_intn  out  NUM_PORTS  interrupt (active low) to each port
- mcu_sclk  out  1  selected SPI clock to core
- mcu_csn  out  1  selected chip select to core
- mcu_mosi  out  1  selected MOSI to core
- mcu_miso  in  1  core MISO
- mcu_intn  in  1  core interrupt
- port_sel  out  max(1,clog2(NUM_PORTS))  currently selected port index
- switching  out  1  high while in GUARD state

Behaviour:
- Reset state (async on reset_n low): state=RUN, port_sel=DEFAULT_PORT, switching=0, all counters 0, synchronizers preset to 1.
- Data path is combinational in RUN: mcu_sclk/mcu_csn/mcu_mosi = port_*[port_sel]. The SPI signals are never registered.
- In GUARD, mcu_csn=1, mcu_sclk=0, mcu_mosi=0.
- FANOUT_ALL=1: every port_miso = mcu_miso and every port_intn = mcu_intn.
- FANOUT_ALL=0: only port_sel (in RUN) gets them. All other ports, and all ports in GUARD, get 1.
- csn_s[i] is port_csn[i] through SYNC_STAGES flops. A detect counter per port clears when csn_s[i]=1, otherwise increments and saturates at DETECT_CYCLES. req[i] = (counter==DETECT_CYCLES).
- idle = (csn_s[port_sel]==1). An idle counter counts consecutive idle cycles, saturates at TIMEOUT_CYCLES, and clears on non-idle or on any port_sel change.
- RUN -> GUARD when idle and any req[i] with i!=port_sel. Target is the lowest such index.
- Otherwise RUN -> GUARD when TIMEOUT_CYCLES>0, port_sel!=DEFAULT_PORT and the idle counter reaches TIMEOUT_CYCLES. Target is DEFAULT_PORT.
- A request and a timeout in the same cycle: the request wins.
- Never switch while the selected csn_s=0, even if requests are pending.
- GUARD: switching=1 for exactly GUARD_CYCLES cycles. Target is latched on entry. Requests arriving during GUARD are ignored until back in RUN.
- On GUARD exit, port_sel<=target in the same edge that returns state to RUN.
- Request to the already-selected port: no action.
- Glitches on port_csn shorter than DETECT_CYCLES do not cause a switch. Floating-high unused ports never request.
- reset_n asserted mid-GUARD: immediate return to reset state. No partial switch is retained.

Test Plan:
- Reset, all csn=1 -> port_sel=DEFAULT_PORT=0, switching=0; port 0 sclk/mosi toggles seen on mcu_* combinationally; both port_miso follow mcu_miso.
- Port 1 csn low 16 cycles while port 0 idle -> switching=1 for exactly 4 cycles with mcu_csn=1, then port_sel=1; port 1 traffic passes.
- Port 1 csn low 10 cycles then high -> no switch, port_sel stays 0.
- Port 0 mid-transfer (csn_s=0) while port 1 requests -> no switch until port 0 csn rises; switch begins 1 cycle after idle is seen.
- TIMEOUT_CYCLES=100, selected port 1 idle 99 cycles -> stays 1; at 100 -> GUARD then port_sel=0. TIMEOUT_CYCLES=0 -> port 1 kept indefinitely.
- NUM_PORTS=4, FANOUT_ALL=0, ports 2 and 3 request together -> port 2 selected; port_miso[3:0] = {1,mcu_miso,1,1}; reset_n pulsed in GUARD -> port_sel=0 immediately.
